trace_operand_streamer: RTL and testbench

- Holds one 4x2 complex Y matrix and one 4x2 complex G matrix, loaded through a random-access write port.
- On `start`, streams the matrices row by row into the trace(YH*G) calculator, optionally conjugating Y.
- After a programmable MAC latency it captures the calculator's trace result and presents it with a one-cycle valid pulse.
- Sits between the detector's matrix buffers and the trace calculator in the x-metric path, and is the producer end of that calculator's interface.

---
 rtl/trace_operand_streamer.sv | 227 ++++++++++++++++++++++
 tb/tb_trace_operand_streamer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_operand_streamer.sv
// trace_operand_streamer
// Holds one ROWS x 2 complex Y matrix and one ROWS x 2 complex G matrix and
// streams them row by row into the trace(Y^H * G) calculator. Y imaginary
// parts are optionally negated with saturation. After MAC_LAT wait cycles the
// calculator result is captured and flagged with a one-cycle valid pulse.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_row/wr_col/wr_r/wr_i
//                             random-access buffer write (sel 0 = Y, 1 = G)
//   wr_drop                   pulse: a write arrived while busy and was discarded
//   start                     begin one frame (honoured only in IDLE)
//   busy                      frame in progress (stream, wait and capture)
//   cal_en, row_idx           row-valid strobe and row number for the calculator
//   y_r0_*, y_r1_*            Y[k][0], Y[k][1] (optionally conjugated)
//   g_c0_*, g_c1_*            G[k][0], G[k][1]
//   trace_in_r/_i             calculator result
//   trace_r/_i, trace_valid   captured result and its capture pulse
//
// state   | meaning
// IDLE    | waiting for start, buffer writes accepted
// STREAM  | presenting rows 0..ROWS-1, cal_en high
// WAIT    | letting the calculator MAC pipeline settle
// CAPTURE | trace registered, trace_valid high for this cycle
module trace_operand_streamer #(
  parameter int N       = 16,
  parameter int ROWS    = 4,
  parameter int MAC_LAT = 1,
  parameter int CONJ_Y  = 1,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [RW-1:0] wr_row,
  input  logic          wr_col,
  input  logic [N-1:0]  wr_r,
  input  logic [N-1:0]  wr_i,
  output logic          wr_drop,
  input  logic          start,
  output logic          busy,
  output logic          cal_en,
  output logic [N-1:0]  y_r0_r,
  output logic [N-1:0]  y_r0_i,
  output logic [N-1:0]  y_r1_r,
  output logic [N-1:0]  y_r1_i,
  output logic [N-1:0]  g_c0_r,
  output logic [N-1:0]  g_c0_i,
  output logic [N-1:0]  g_c1_r,
  output logic [N-1:0]  g_c1_i,
  output logic [RW-1:0] row_idx,
  input  logic [N-1:0]  trace_in_r,
  input  logic [N-1:0]  trace_in_i,
  output logic [N-1:0]  trace_r,
  output logic [N-1:0]  trace_i,
  output logic          trace_valid
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_CAPTURE} state_t;

  localparam logic [3:0]    LAT_M1   = 4'(MAC_LAT - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t       state;
  logic [3:0]   wait_cnt;

  logic [N-1:0] y_re [ROWS][2];
  logic [N-1:0] y_im [ROWS][2];
  logic [N-1:0] g_re [ROWS][2];
  logic [N-1:0] g_im [ROWS][2];

  logic          wr_ok;
  logic [RW-1:0] ld_row;
  logic [N-1:0]  rd_yr [2];
  logic [N-1:0]  rd_yi [2];
  logic [N-1:0]  rd_yc [2];
  logic [N-1:0]  rd_gr [2];
  logic [N-1:0]  rd_gi [2];

  // Most negative input has no positive counterpart; clamp to max.
  function automatic logic [N-1:0] neg_sat(input logic [N-1:0] x);
    if (x == {1'b1, {(N-1){1'b0}}}) return {1'b0, {(N-1){1'b1}}};
    return -x;
  endfunction

  assign wr_ok = wr_en && (state == S_IDLE);

  // Row to load into the operand registers at the next edge. In IDLE this is
  // row 0 for a frame that may start now; a write accepted in that same cycle
  // is forwarded so the frame streams the freshly written value.
  always_comb begin
    ld_row = (state == S_IDLE) ? '0 : row_idx + RW'(1);
    for (int c = 0; c < 2; c++) begin
      rd_yr[c] = y_re[ld_row][c];
      rd_yi[c] = y_im[ld_row][c];
      rd_gr[c] = g_re[ld_row][c];
      rd_gi[c] = g_im[ld_row][c];
    end
    if (wr_ok && (wr_row == ld_row)) begin
      if (wr_sel) begin
        rd_gr[wr_col] = wr_r;
        rd_gi[wr_col] = wr_i;
      end else begin
        rd_yr[wr_col] = wr_r;
        rd_yi[wr_col] = wr_i;
      end
    end
    for (int c = 0; c < 2; c++) begin
      rd_yc[c] = (CONJ_Y != 0) ? neg_sat(rd_yi[c]) : rd_yi[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < 2; c++) begin
          y_re[r][c] <= '0;
          y_im[r][c] <= '0;
          g_re[r][c] <= '0;
          g_im[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel) begin
        g_re[wr_row][wr_col] <= wr_r;
        g_im[wr_row][wr_col] <= wr_i;
      end else begin
        y_re[wr_row][wr_col] <= wr_r;
        y_im[wr_row][wr_col] <= wr_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      cal_en      <= 1'b0;
      row_idx     <= '0;
      wr_drop     <= 1'b0;
      trace_valid <= 1'b0;
      trace_r     <= '0;
      trace_i     <= '0;
      y_r0_r      <= '0;
      y_r0_i      <= '0;
      y_r1_r      <= '0;
      y_r1_i      <= '0;
      g_c0_r      <= '0;
      g_c0_i      <= '0;
      g_c1_r      <= '0;
      g_c1_i      <= '0;
    end else begin
      wr_drop     <= wr_en && (state != S_IDLE);
      trace_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_STREAM;
            busy    <= 1'b1;
            cal_en  <= 1'b1;
            row_idx <= '0;
            y_r0_r  <= rd_yr[0];
            y_r0_i  <= rd_yc[0];
            y_r1_r  <= rd_yr[1];
            y_r1_i  <= rd_yc[1];
            g_c0_r  <= rd_gr[0];
            g_c0_i  <= rd_gi[0];
            g_c1_r  <= rd_gr[1];
            g_c1_i  <= rd_gi[1];
          end
        end
        S_STREAM: begin
          if (row_idx == LAST_ROW) begin
            cal_en   <= 1'b0;
            row_idx  <= '0;
            wait_cnt <= '0;
            y_r0_r   <= '0;
            y_r0_i   <= '0;
            y_r1_r   <= '0;
            y_r1_i   <= '0;
            g_c0_r   <= '0;
            g_c0_i   <= '0;
            g_c1_r   <= '0;
            g_c1_i   <= '0;
            if (MAC_LAT == 0) begin
              // Zero latency: the result is ready at the end of the last row.
              trace_r     <= trace_in_r;
              trace_i     <= trace_in_i;
              trace_valid <= 1'b1;
              state       <= S_CAPTURE;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            row_idx <= row_idx + RW'(1);
            y_r0_r  <= rd_yr[0];
            y_r0_i  <= rd_yc[0];
            y_r1_r  <= rd_yr[1];
            y_r1_i  <= rd_yc[1];
            g_c0_r  <= rd_gr[0];
            g_c0_i  <= rd_gi[0];
            g_c1_r  <= rd_gr[1];
            g_c1_i  <= rd_gi[1];
          end
        end
        S_WAIT: begin
          if (wait_cnt == LAT_M1) begin
            trace_r     <= trace_in_r;
            trace_i     <= trace_in_i;
            trace_valid <= 1'b1;
            state       <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_operand_streamer.sv
module tb_trace_operand_streamer;

  localparam int ROWS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sel, wr_col, start;
  logic [1:0]  wr_row;
  logic [15:0] wr_r, wr_i, trace_in_r, trace_in_i;

  logic        wr_drop [2], busy [2], cal_en [2], trace_valid [2];
  logic [1:0]  row_idx [2];
  logic [15:0] y_r0_r [2], y_r0_i [2], y_r1_r [2], y_r1_i [2];
  logic [15:0] g_c0_r [2], g_c0_i [2], g_c1_r [2], g_c1_i [2];
  logic [15:0] trace_r [2], trace_i [2];
  logic [165:0] act [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance 0: MAC_LAT=1 with conjugation; instance 1: MAC_LAT=0 without.
  trace_operand_streamer #(.N(16), .ROWS(4), .MAC_LAT(1), .CONJ_Y(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_r(wr_r), .wr_i(wr_i), .wr_drop(wr_drop[0]),
    .start(start), .busy(busy[0]), .cal_en(cal_en[0]),
    .y_r0_r(y_r0_r[0]), .y_r0_i(y_r0_i[0]), .y_r1_r(y_r1_r[0]), .y_r1_i(y_r1_i[0]),
    .g_c0_r(g_c0_r[0]), .g_c0_i(g_c0_i[0]), .g_c1_r(g_c1_r[0]), .g_c1_i(g_c1_i[0]),
    .row_idx(row_idx[0]), .trace_in_r(trace_in_r), .trace_in_i(trace_in_i),
    .trace_r(trace_r[0]), .trace_i(trace_i[0]), .trace_valid(trace_valid[0]));

  trace_operand_streamer #(.N(16), .ROWS(4), .MAC_LAT(0), .CONJ_Y(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_r(wr_r), .wr_i(wr_i), .wr_drop(wr_drop[1]),
    .start(start), .busy(busy[1]), .cal_en(cal_en[1]),
    .y_r0_r(y_r0_r[1]), .y_r0_i(y_r0_i[1]), .y_r1_r(y_r1_r[1]), .y_r1_i(y_r1_i[1]),
    .g_c0_r(g_c0_r[1]), .g_c0_i(g_c0_i[1]), .g_c1_r(g_c1_r[1]), .g_c1_i(g_c1_i[1]),
    .row_idx(row_idx[1]), .trace_in_r(trace_in_r), .trace_in_i(trace_in_i),
    .trace_r(trace_r[1]), .trace_i(trace_i[1]), .trace_valid(trace_valid[1]));

  for (genvar m = 0; m < 2; m++) begin : g_pack
    assign act[m] = {busy[m], cal_en[m], trace_valid[m], wr_drop[m], row_idx[m],
                     y_r0_r[m], y_r0_i[m], y_r1_r[m], y_r1_i[m],
                     g_c0_r[m], g_c0_i[m], g_c1_r[m], g_c1_i[m],
                     trace_r[m], trace_i[m]};
  end

  // ---------------- reference model ----------------
  // A frame is described by the edge number ts at which its start was taken;
  // the cycle following edge e has offset j = e - ts + 1 within the frame.
  int ecnt = 0;
  int ts [2] = '{-100, -100};
  logic exp_drop [2] = '{1'b0, 1'b0};
  int cap_r [2] = '{0, 0};
  int cap_i [2] = '{0, 0};
  int br [2][2][4][2];   // [dut][sel][row][col] real
  int bi [2][2][4][2];   // imag

  function automatic int lat(input int m);
    return (m == 0) ? 1 : 0;
  endfunction

  function automatic int nsat(input int x);
    return (x == -32768) ? 32767 : -x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        ts[m] = ecnt - 100;
        exp_drop[m] = 1'b0;
        cap_r[m] = 0;
        cap_i[m] = 0;
        for (int s = 0; s < 2; s++)
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 2; c++) begin
              br[m][s][r][c] = 0;
              bi[m][s][r][c] = 0;
            end
      end
    end else begin
      ecnt++;
      for (int m = 0; m < 2; m++) begin
        int jp;
        bit idle;
        jp = ecnt - ts[m];
        idle = !(jp >= 1 && jp <= ROWS + lat(m) + 1);
        if (jp == ROWS + lat(m)) begin
          cap_r[m] = int'($signed(trace_in_r));
          cap_i[m] = int'($signed(trace_in_i));
        end
        exp_drop[m] = wr_en && !idle;
        if (wr_en && idle) begin
          br[m][wr_sel][wr_row][wr_col] = int'($signed(wr_r));
          bi[m][wr_sel][wr_row][wr_col] = int'($signed(wr_i));
        end
        if (start && idle) ts[m] = ecnt;
      end
    end
  end

  function automatic logic [165:0] expv(input int m);
    int j, k;
    logic bsy, cal, tv;
    logic [1:0] row;
    logic [15:0] yr0, yi0, yr1, yi1, gr0, gi0, gr1, gi1;
    j = ecnt - ts[m] + 1;
    bsy = (j >= 1) && (j <= ROWS + lat(m) + 1);
    cal = (j >= 1) && (j <= ROWS);
    tv  = (j == ROWS + lat(m) + 1);
    row = '0;
    {yr0, yi0, yr1, yi1, gr0, gi0, gr1, gi1} = '0;
    if (cal) begin
      k = j - 1;
      row = 2'(k);
      yr0 = 16'(br[m][0][k][0]);
      yr1 = 16'(br[m][0][k][1]);
      yi0 = 16'((m == 0) ? nsat(bi[m][0][k][0]) : bi[m][0][k][0]);
      yi1 = 16'((m == 0) ? nsat(bi[m][0][k][1]) : bi[m][0][k][1]);
      gr0 = 16'(br[m][1][k][0]);
      gi0 = 16'(bi[m][1][k][0]);
      gr1 = 16'(br[m][1][k][1]);
      gi1 = 16'(bi[m][1][k][1]);
    end
    return {bsy, cal, tv, exp_drop[m], row, yr0, yi0, yr1, yi1, gr0, gi0, gr1, gi1,
            16'(cap_r[m]), 16'(cap_i[m])};
  endfunction

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [165:0] e;
      e = expv(m);
      n_chk++;
      if (act[m] !== e) begin
        n_fail++;
        $display("FAIL cycle_dut%0d t=%0t got=%h want=%h", m, $time, act[m], e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [165:0] got, input logic [165:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wr(input logic s, input logic [1:0] r, input logic c,
                    input logic [15:0] vr, input logic [15:0] vi);
    wr_en = 1'b1; wr_sel = s; wr_row = r; wr_col = c; wr_r = vr; wr_i = vi;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = 1'b0;
    wr_r = '0; wr_i = '0; start = 1'b0; trace_in_r = '0; trace_in_i = '0;
    #1;
    chk("reset_a", act[0], '0);
    chk("reset_b", act[1], '0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Frame 1: all elements (256, 0)
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 2; c++)
          wr(1'(s), 2'(r), 1'(c), 16'd256, 16'd0);
    start = 1'b1; cyc(); start = 1'b0;
    cnt = 0;
    for (int p = 1; p <= 6; p++) begin
      if (p <= 4) begin
        chk("f1_row", {164'd0, row_idx[0]}, 166'(p - 1));
        chk("f1_real", {y_r0_r[0], y_r1_r[0], g_c0_r[0], g_c1_r[0]}, {4{16'd256}});
        chk("f1_imag", {y_r0_i[0], y_r1_i[0], g_c0_i[0], g_c1_i[0]}, '0);
      end
      if (cal_en[0]) cnt++;
      cyc();
    end
    chk("f1_cal_cycles", 166'(cnt), 166'd4);
    repeat (2) cyc();

    // Frame 2: conjugation, saturation, capture timing, start in WAIT ignored
    wr(1'b0, 2'd2, 1'b1, 16'd100, 16'd50);
    wr(1'b1, 2'd2, 1'b1, 16'd7, 16'(-9));
    wr(1'b0, 2'd0, 1'b0, 16'd5, 16'h8000);
    wr(1'b0, 2'd0, 1'b1, 16'd6, 16'h7fff);
    start = 1'b1; cyc(); start = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      trace_in_r = (p == 4) ? 16'd77 : (p == 5) ? 16'd512 : 16'd0;
      trace_in_i = (p == 4) ? 16'(-77) : (p == 5) ? 16'(-3) : 16'd0;
      start = (p == 5);
      if (p == 1) begin
        chk("sat_a_y0i", {150'd0, y_r0_i[0]}, 166'h7fff);
        chk("neg_a_y1i", {150'd0, y_r1_i[0]}, 166'h8001);
        chk("pass_b_y0i", {150'd0, y_r0_i[1]}, 166'h8000);
      end
      if (p == 3) begin
        chk("conj_a_row2", {y_r1_r[0], y_r1_i[0], g_c1_r[0], g_c1_i[0]},
            {16'd100, 16'(-50), 16'd7, 16'(-9)});
        chk("pass_b_y1i", {150'd0, y_r1_i[1]}, 166'd50);
      end
      if (p == 5) begin
        chk("b_valid_t5", {165'd0, trace_valid[1]}, 166'd1);
        chk("b_trace", {trace_r[1], trace_i[1]}, {16'd77, 16'(-77)});
        chk("a_novalid_t5", {165'd0, trace_valid[0]}, 166'd0);
      end
      if (p == 6) begin
        chk("a_valid_t6", {165'd0, trace_valid[0]}, 166'd1);
        chk("a_trace", {trace_r[0], trace_i[0]}, {16'd512, 16'hfffd});
        chk("b_idle_t6", {busy[1], cal_en[1], trace_valid[1]}, 166'd0);
      end
      if (p == 7) begin
        chk("a_idle_t7", {busy[0], cal_en[0], trace_valid[0]}, 166'd0);
        chk("a_trace_held", {trace_r[0], trace_i[0]}, {16'd512, 16'hfffd});
        chk("model_cap_a", 166'(16'(cap_r[0])), 166'd512);
      end
      if (p == 8) chk("no_second_frame", {cal_en[0], cal_en[1]}, 166'd0);
      cyc();
    end
    start = 1'b0; trace_in_r = '0; trace_in_i = '0;

    // Write during STREAM is dropped
    start = 1'b1; cyc(); start = 1'b0;
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 1'b0; wr_r = 16'd1; wr_i = 16'd1;
    cyc();
    wr_en = 1'b0;
    chk("drop_pulse", {wr_drop[0], wr_drop[1]}, 166'b11);
    cyc();
    chk("drop_once", {wr_drop[0], wr_drop[1]}, 166'b00);
    repeat (5) cyc();
    start = 1'b1; cyc(); start = 1'b0; cyc();
    chk("old_y10", {row_idx[0], y_r0_r[0], y_r0_i[0]}, {2'd1, 16'd256, 16'd0});
    repeat (6) cyc();

    // Reset mid-frame
    start = 1'b1; cyc(); start = 1'b0; cyc();
    rst = 1'b1;
    #1;
    chk("rst_mid_a", act[0], '0);
    chk("rst_mid_b", act[1], '0);
    cyc();
    rst = 1'b0;
    repeat (8) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      chk("cleared_ops", {cal_en[0], y_r0_r[0], y_r0_i[0], y_r1_r[0], y_r1_i[0],
                          g_c0_r[0], g_c0_i[0], g_c1_r[0], g_c1_i[0]}, {1'b1, 128'd0});
      cyc();
    end
    repeat (3) cyc();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_sel = 1'($urandom);
      wr_row = 2'($urandom);
      wr_col = 1'($urandom);
      wr_r   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      wr_i   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      trace_in_r = 16'($urandom);
      trace_in_i = 16'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; start = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
